// File: rtl/fifo_byte_reader.sv
// fifo_byte_reader: reads words from a non-fall-through synchronous FIFO and
// streams them out as bytes (least-significant byte first) over a
// valid/ready handshake, for a requested number of bytes per readout.
//
// Optional feature macro: FIFO_BYTE_READER_PREFETCH_EN
//   undefined : between words the block returns to FETCH/LOAD, which leaves a
//               two-cycle gap in out_valid.
//   defined   : a one-word prefetch buffer is filled while the current word
//               is being shifted out, so consecutive words stream with no gap.
module fifo_byte_reader #(
  parameter int pDATA_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [31:0]            req_bytes,
  input  logic                   fifo_empty,
  output logic                   fifo_ren,
  input  logic [pDATA_WIDTH-1:0] fifo_rdata,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            bytes_remaining
);

  // Bytes per FIFO word and the width of the byte index within a word.
  localparam int NB    = pDATA_WIDTH / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    SHIFT = 2'd3
  } state_t;

  state_t                 r_state;
  logic [pDATA_WIDTH-1:0] r_shift;
  logic [IDX_W-1:0]       r_idx;
  logic [31:0]            r_remaining;
  logic                   r_busy;
  logic                   r_done;

  logic w_fetch_ren;
  logic w_last_byte;

  // The byte currently presented is the last one of its word.
  assign w_last_byte = (r_idx == LAST_IDX);

`ifdef FIFO_BYTE_READER_PREFETCH_EN
  localparam logic [31:0] NB32 = 32'(NB);

  logic [pDATA_WIDTH-1:0] r_pf_buf;
  logic                   r_pf_valid;
  logic                   r_pf_pending;
  logic [31:0]            w_unsent;
  logic                   w_pf_ren;

  // Bytes of the current word not yet handed to the consumer.
  assign w_unsent = NB32 - {{(32 - IDX_W){1'b0}}, r_idx};

  // Prefetch only when another word will actually be needed, so a readout
  // never pulls a word out of the FIFO that it would then throw away.
  assign w_pf_ren = (r_state == SHIFT) && !r_pf_valid && !r_pf_pending &&
                    !fifo_empty && (r_remaining > w_unsent);

  // A word already held (or in flight) in the prefetch path satisfies FETCH.
  assign w_fetch_ren = (r_state == FETCH) && !fifo_empty &&
                       !r_pf_valid && !r_pf_pending;
  assign fifo_ren    = w_fetch_ren || w_pf_ren;
`else
  assign w_fetch_ren = (r_state == FETCH) && !fifo_empty;
  assign fifo_ren    = w_fetch_ren;
`endif

  assign out_valid       = (r_state == SHIFT);
  assign out_data        = r_shift[7:0];
  assign busy            = r_busy;
  assign done            = r_done;
  assign bytes_remaining = r_remaining;

  // Readout sequencer: owns state, shift register, byte counters and the
  // optional prefetch buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_idx       <= '0;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef FIFO_BYTE_READER_PREFETCH_EN
      r_pf_buf     <= '0;
      r_pf_valid   <= 1'b0;
      r_pf_pending <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef FIFO_BYTE_READER_PREFETCH_EN
      // Data for a prefetch read arrives one cycle after the read strobe.
      // State branches below may consume it directly and override this.
      if (r_pf_pending) begin
        r_pf_buf   <= fifo_rdata;
        r_pf_valid <= 1'b1;
      end
      r_pf_pending <= w_pf_ren;
`endif
      case (r_state)
        IDLE: begin
          if (start) begin
            r_remaining <= req_bytes;
            r_idx       <= '0;
            if (req_bytes == 32'd0) begin
              // Empty request: acknowledge immediately, never touch the FIFO.
              r_done <= 1'b1;
            end else begin
              r_busy  <= 1'b1;
              r_state <= FETCH;
            end
          end
        end

        FETCH: begin
`ifdef FIFO_BYTE_READER_PREFETCH_EN
          if (r_pf_valid || r_pf_pending) begin
            r_shift    <= r_pf_valid ? r_pf_buf : fifo_rdata;
            r_pf_valid <= 1'b0;
            r_idx      <= '0;
            r_state    <= SHIFT;
          end else if (w_fetch_ren) begin
            r_state <= LOAD;
          end
`else
          if (w_fetch_ren) begin
            r_state <= LOAD;
          end
`endif
        end

        LOAD: begin
          r_shift <= fifo_rdata;
          r_idx   <= '0;
          r_state <= SHIFT;
        end

        SHIFT: begin
          if (out_ready) begin
            r_shift     <= r_shift >> 8;
            r_remaining <= r_remaining - 32'd1;
            r_idx       <= w_last_byte ? '0 : r_idx + IDX_W'(1);
            if (r_remaining == 32'd1) begin
              // Readout complete; any bytes left in this word are dropped.
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
`ifdef FIFO_BYTE_READER_PREFETCH_EN
              r_pf_valid   <= 1'b0;
              r_pf_pending <= 1'b0;
`endif
            end else if (w_last_byte) begin
`ifdef FIFO_BYTE_READER_PREFETCH_EN
              if (r_pf_valid) begin
                r_shift    <= r_pf_buf;
                r_pf_valid <= 1'b0;
              end else if (r_pf_pending) begin
                r_shift    <= fifo_rdata;
                r_pf_valid <= 1'b0;
              end else begin
                r_state <= FETCH;
              end
`else
              r_state <= FETCH;
`endif
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_byte_reader.sv
// Testbench for fifo_byte_reader: table of readouts against a behavioural
// FIFO, plus hand-written reset sequences. Honours FIFO_BYTE_READER_PREFETCH_EN
// for the expected inter-word gap.
module tb_fifo_byte_reader;

  localparam int W = 64;
`ifdef FIFO_BYTE_READER_PREFETCH_EN
  localparam int GAP = 0;
`else
  localparam int GAP = 2;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [31:0]   req_bytes;
  logic          fifo_empty;
  logic          fifo_ren;
  logic [W-1:0]  fifo_rdata;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic [31:0]   bytes_remaining;

  always #5 clk = ~clk;

  fifo_byte_reader #(.pDATA_WIDTH(W)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .req_bytes       (req_bytes),
    .fifo_empty      (fifo_empty),
    .fifo_ren        (fifo_ren),
    .fifo_rdata      (fifo_rdata),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .busy            (busy),
    .done            (done),
    .bytes_remaining (bytes_remaining)
  );

  // Behavioural non-fall-through FIFO: data appears the cycle after ren.
  logic [W-1:0] mem [0:31];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_ren && (wr_ptr != rd_ptr)) begin
      fifo_rdata <= mem[rd_ptr % 32];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int push_idx = 0;
  int cons_idx = 0;

  // Word w carries bytes 8w+1 .. 8w+8, least-significant first.
  function automatic logic [W-1:0] gen(input int w);
    logic [W-1:0] r;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = 8'(8*w + k + 1);
    return r;
  endfunction

  task automatic push_word();
    mem[wr_ptr % 32] = gen(push_idx);
    wr_ptr   = wr_ptr + 1;
    push_idx = push_idx + 1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int req;          // req_bytes
    int push_before;  // words written before start
    int push_late;    // words written at offset 'delay'
    int delay;        // cycle offset of the late write
    bit toggle;       // out_ready toggles 0101...
    int exp_first;    // expected first out_valid offset (-1: never)
    int exp_ren;      // expected number of fifo_ren cycles
  } vec_t;

  task automatic run_readout(input vec_t v, input int id);
    int   bytes_got [0:63];
    int   hs_off [0:63];
    int   nb = 0;
    int   first_valid = -1;
    int   first_ren = -1;
    int   ren_cnt = 0;
    int   ren_empty = 0;
    int   done_cnt = 0;
    int   done_off = -1;
    int   unstable = 0;
    int   busy1 = -1;
    int   rem1 = -1;
    int   off = 0;
    int   tail = 0;
    int   exp_first_ren;
    int   last;
    bit   pv = 1'b0;
    bit   pr = 1'b0;
    logic [7:0] pd = 8'h00;

    @(negedge clk);
    for (int k = 0; k < v.push_before; k++) push_word();
    start     = 1'b1;
    req_bytes = v.req;
    out_ready = 1'b1;
    while (off < 300 && tail < 3) begin
      @(negedge clk);
      off++;
      start = 1'b0;
      // A second start during the readout must be ignored.
      if (off == 2 && v.req > 0) begin
        start     = 1'b1;
        req_bytes = 32'hFF;
      end
      if (v.push_late > 0 && off == v.delay)
        for (int k = 0; k < v.push_late; k++) push_word();
      out_ready = v.toggle ? ((off % 2) == 0) : 1'b1;
      #1;
      if (fifo_ren) begin
        ren_cnt++;
        if (first_ren < 0) first_ren = off;
      end
      if (fifo_ren && fifo_empty) ren_empty++;
      if (out_valid && first_valid < 0) first_valid = off;
      if (pv && !pr && (!out_valid || out_data != pd)) unstable++;
      if (out_valid && out_ready) begin
        if (nb < 64) begin
          bytes_got[nb] = out_data;
          hs_off[nb]    = off;
        end
        nb++;
      end
      if (done) begin
        done_cnt++;
        if (done_off < 0) done_off = off;
      end
      if (off == 1) begin
        busy1 = busy;
        rem1  = bytes_remaining;
      end
      pv = out_valid;
      pr = out_ready;
      pd = out_data;
      if (done_cnt > 0) tail++;
    end
    start = 1'b0;

    exp_first_ren = (v.req == 0) ? -1 : ((v.delay > 0) ? v.delay : 1);
    chk($sformatf("v%0d done_count", id), done_cnt, 1);
    chk($sformatf("v%0d busy_after_start", id), busy1, (v.req > 0) ? 1 : 0);
    chk($sformatf("v%0d remaining_latched", id), rem1, v.req);
    chk($sformatf("v%0d byte_count", id), nb, v.req);
    for (int i = 0; i < nb && i < 64; i++) begin
      chk($sformatf("v%0d byte%0d_value", id, i), bytes_got[i],
          (8*(cons_idx + i/8) + (i % 8) + 1) % 256);
      if (!v.toggle)
        chk($sformatf("v%0d byte%0d_cycle", id, i), hs_off[i],
            v.exp_first + i + (i/8)*GAP);
    end
    chk($sformatf("v%0d first_valid", id), first_valid, v.exp_first);
    chk($sformatf("v%0d first_ren", id), first_ren, exp_first_ren);
    chk($sformatf("v%0d ren_cycles", id), ren_cnt, v.exp_ren);
    chk($sformatf("v%0d ren_while_empty", id), ren_empty, 0);
    chk($sformatf("v%0d data_unstable", id), unstable, 0);
    last = (nb > 0 && nb <= 64) ? hs_off[nb-1] : 0;
    chk($sformatf("v%0d done_cycle", id), done_off, last + 1);
    chk($sformatf("v%0d remaining_end", id), bytes_remaining, 0);
    chk($sformatf("v%0d busy_end", id), busy, 0);
    $display("readout %0d: req=%0d bytes=%0d ren=%0d first_valid=%0d done_at=%0d",
             id, v.req, nb, ren_cnt, first_valid, done_off);
    cons_idx += (v.req + 7) / 8;
  endtask

  vec_t vecs [0:7];

  initial begin
    int d;
    vecs[0] = '{req: 8,  push_before: 1, push_late: 0, delay: 0,  toggle: 1'b0, exp_first: 3,  exp_ren: 1};
    vecs[1] = '{req: 5,  push_before: 2, push_late: 0, delay: 0,  toggle: 1'b0, exp_first: 3,  exp_ren: 1};
    vecs[2] = '{req: 8,  push_before: 0, push_late: 0, delay: 0,  toggle: 1'b0, exp_first: 3,  exp_ren: 1};
    vecs[3] = '{req: 16, push_before: 2, push_late: 0, delay: 0,  toggle: 1'b0, exp_first: 3,  exp_ren: 2};
    vecs[4] = '{req: 0,  push_before: 0, push_late: 0, delay: 0,  toggle: 1'b0, exp_first: -1, exp_ren: 0};
    vecs[5] = '{req: 8,  push_before: 0, push_late: 1, delay: 10, toggle: 1'b1, exp_first: 12, exp_ren: 1};
    vecs[6] = '{req: 20, push_before: 3, push_late: 0, delay: 0,  toggle: 1'b1, exp_first: 3,  exp_ren: 3};
    vecs[7] = '{req: 3,  push_before: 1, push_late: 0, delay: 0,  toggle: 1'b0, exp_first: 3,  exp_ren: 1};

    // Reset state.
    reset     = 1'b1;
    start     = 1'b0;
    req_bytes = 32'd0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset fifo_ren", fifo_ren, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset bytes_remaining", bytes_remaining, 0);
    $display("reset: ren=%0d valid=%0d busy=%0d done=%0d rem=%0d",
             fifo_ren, out_valid, busy, done, bytes_remaining);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_readout(vecs[i], i);

    // Reset in the middle of SHIFT with the consumer stalled.
    @(negedge clk);
    push_word();
    start     = 1'b1;
    req_bytes = 32'd8;
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("midrst valid_before", out_valid, 1);
    chk("midrst data_before", out_data, (8*cons_idx + 1) % 256);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst out_valid", out_valid, 0);
    chk("midrst busy", busy, 0);
    chk("midrst bytes_remaining", bytes_remaining, 0);
    chk("midrst done", done, 0);
    chk("midrst out_data", out_data, 0);
    reset = 1'b0;
    d = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      if (done) d++;
    end
    chk("midrst no_done", d, 0);
    $display("mid-shift reset: valid=%0d busy=%0d rem=%0d done_pulses=%0d",
             out_valid, busy, bytes_remaining, d);
    cons_idx++;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_byte_reader.md
FIFO_BYTE_READER -- requirements
Module: fifo_byte_reader

Interface
REQ-001 Parameter pDATA_WIDTH, default 64: FIFO word width; SHALL be a multiple of 8, minimum 16.
REQ-002 clk  input  1  single clock for all logic.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 start  input  1  one-cycle pulse that begins a readout of req_bytes bytes.
REQ-005 req_bytes  input  32  byte count for the readout, sampled when start is accepted.
REQ-006 fifo_empty  input  1  empty flag from the upstream synchronous FIFO.
REQ-007 fifo_ren  output  1  FIFO read enable, combinational from state.
REQ-008 fifo_rdata  input  pDATA_WIDTH  FIFO data, valid the cycle after fifo_ren (non-fall-through FIFO).
REQ-009 out_data  output  8  byte to consumer.
REQ-010 out_valid  output  1  out_data valid.
REQ-011 out_ready  input  1  consumer accepts the byte when out_valid and out_ready are both high.
REQ-012 busy  output  1  high from accepted start until done.
REQ-013 done  output  1  one-cycle pulse when the readout completes.
REQ-014 bytes_remaining  output  32  bytes not yet transferred in the current readout.

Function
REQ-015 States: IDLE, FETCH, LOAD, SHIFT; done SHALL be a registered pulse asserted on return to IDLE.
REQ-016 IDLE: start SHALL latch req_bytes into bytes_remaining and set busy; if req_bytes==0, done SHALL pulse next cycle and the block SHALL stay IDLE with busy low.
REQ-017 start while busy SHALL be ignored.
REQ-018 FETCH: fifo_ren = !fifo_empty; the block SHALL wait in FETCH while fifo_empty and move to LOAD on the cycle fifo_ren is high.
REQ-019 LOAD: fifo_rdata SHALL be captured into the shift register; next state SHALL be SHIFT.
REQ-020 SHIFT: out_valid=1, out_data=shift register bits [7:0] (least-significant byte first); out_data SHALL hold stable while out_ready is low.
REQ-021 Each handshake SHALL shift the register right by 8, decrement bytes_remaining by 1 and advance the byte index mod pDATA_WIDTH/8.
REQ-022 Handshake making bytes_remaining 0 SHALL go to IDLE, pulse done, clear busy; the remaining bytes of the current word SHALL be discarded.
REQ-023 Handshake on the last byte of a word with bytes_remaining still nonzero SHALL go to FETCH.
REQ-024 fifo_ren SHALL never be high while fifo_empty is high; out_valid SHALL be low outside SHIFT.
REQ-025 Latency with the FIFO non-empty: start in cycle N -> fifo_ren in N+1, first out_valid in N+3.

Reset
REQ-026 reset SHALL force IDLE, clear bytes_remaining, the byte index, the shift register and the prefetch buffer, and drive fifo_ren, out_valid, out_data, busy and done to 0 on the next clock edge.
REQ-027 reset mid-readout SHALL abort without a done pulse; words already read from the FIFO SHALL be lost.

Configuration
REQ-028 Macro FIFO_BYTE_READER_PREFETCH_EN.
- Undefined: two-cycle out_valid bubble (FETCH, LOAD) between words.
- Defined: a one-word prefetch buffer.
  - In SHIFT, when the buffer is empty, fifo_empty is low and bytes_remaining exceeds the unsent bytes of the current word, fifo_ren SHALL assert for one cycle; fifo_rdata SHALL be captured into the buffer the next cycle.
  - On the last-byte handshake of a word, a valid buffer SHALL load the shift register directly and stay in SHIFT, giving zero bubble.
  - An empty buffer SHALL fall back to FETCH.

Verification
REQ-029 pDATA_WIDTH=64; FIFO holds 0x0807060504030201; start with req_bytes=8, out_ready=1 -> bytes 01..08 on consecutive cycles from N+3, done pulses once, fifo_ren high exactly one cycle.
REQ-030 req_bytes=5, same word -> bytes 01..05, done pulses once, the remaining 3 bytes are discarded, a second start reads the next FIFO word.
REQ-031 req_bytes=16, two words, out_ready=1 -> gap of 2 cycles between byte 8 and byte 9 without the macro, 0 cycles with the macro.
REQ-032 FIFO empty for 10 cycles after start, then a word is written -> fifo_ren stays 0 during the empty period, then output proceeds normally; out_ready toggled 1010... -> out_data stable while not accepted.
REQ-033 req_bytes=0 -> done pulses in N+1, fifo_ren never asserts; reset asserted mid-SHIFT -> next cycle out_valid=0, busy=0, bytes_remaining=0, no done pulse.
